// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD types, field moduli and helpers for the century clock
package clock_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HOUR_MOD = 24;
  localparam int YEAR_MOD = 100;
  function automatic logic [6:0] bcd2bin(bcd_digit_t tens, bcd_digit_t ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction
endpackage

// File: rtl/bcd_mod_counter_digit.sv
// bcd_digit: one BCD digit with up/down step, programmable wrap limit and parallel load
module bcd_digit
  import clock_pkg::*;
#(
  parameter bcd_digit_t RST = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  bcd_digit_t limit,
  output bcd_digit_t q,
  output bcd_digit_t d,
  output logic       tc
);
  // next value: load wins, otherwise step with wrap at limit (up) or 0 (down)
  always_comb begin
    tc = dir ? q == 4'd0 : q == limit;
    d  = ld ? ld_val : !en ? q : dir ? (tc ? limit : q - 4'd1) : (tc ? 4'd0 : q + 4'd1);
  end
  // digit register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= RST;
    else q <= d;
endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD modulo counter with up/down, clear and validated load
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MODULUS   = 60,
  parameter int MIN_VALUE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       dir_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  bcd_digit_t load_ones_i,
  input  bcd_digit_t load_tens_i,
  output bcd_digit_t ones_o,
  output bcd_digit_t tens_o,
  output logic       carry_o,
  output logic       at_max_o,
  output logic       load_err_o
);
  localparam int MAX_VALUE = MIN_VALUE + MODULUS - 1;
  localparam bcd_digit_t MIN_O = 4'(MIN_VALUE % 10);
  localparam bcd_digit_t MIN_T = 4'(MIN_VALUE / 10);
  localparam bcd_digit_t MAX_O = 4'(MAX_VALUE % 10);
  localparam bcd_digit_t MAX_T = 4'(MAX_VALUE / 10);
  logic [6:0] ld_bin;
  logic ld_ok, at_top, at_min, up_wrap, dn_wrap, step, ld_en, ones_tc, tens_tc;
  bcd_digit_t ld_o, ld_t, ones_d, tens_d;
  // request arbitration: clear > load > tick; wraps are done as a load of the opposite end
  always_comb begin
    ld_bin  = bcd2bin(load_tens_i, load_ones_i);
    ld_ok   = load_ones_i <= 4'd9 && load_tens_i <= 4'd9 && ld_bin >= 7'(MIN_VALUE) && ld_bin <= 7'(MAX_VALUE);
    at_top  = ones_o == MAX_O && tens_o == MAX_T;
    at_min  = ones_o == MIN_O && tens_o == MIN_T;
    up_wrap = !clear_i && !load_i && tick_i && !dir_i && at_top;
    dn_wrap = !clear_i && !load_i && tick_i && dir_i && at_min;
    step    = !clear_i && !load_i && tick_i && !up_wrap && !dn_wrap;
    ld_en   = clear_i || (load_i && ld_ok) || up_wrap || dn_wrap;
    ld_o    = clear_i || up_wrap ? MIN_O : dn_wrap ? MAX_O : load_ones_i;
    ld_t    = clear_i || up_wrap ? MIN_T : dn_wrap ? MAX_T : load_tens_i;
  end
  bcd_digit #(.RST(MIN_O)) u_ones (
    .clk(clk), .rst_n(rst_n), .en(step), .dir(dir_i), .ld(ld_en), .ld_val(ld_o),
    .limit(4'd9), .q(ones_o), .d(ones_d), .tc(ones_tc)
  );
  bcd_digit #(.RST(MIN_T)) u_tens (
    .clk(clk), .rst_n(rst_n), .en(step && ones_tc), .dir(dir_i), .ld(ld_en), .ld_val(ld_t),
    .limit(4'd9), .q(tens_o), .d(tens_d), .tc(tens_tc)
  );
  // registered pulses and top-value flag taken from the next count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      carry_o    <= 1'b0;
      at_max_o   <= 1'b0;
      load_err_o <= 1'b0;
    end else begin
      carry_o    <= up_wrap || dn_wrap;
      at_max_o   <= ones_d == MAX_O && tens_d == MAX_T;
      load_err_o <= !clear_i && load_i && !ld_ok;
    end
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: random and directed checks of several counter configurations against a value model
module tb_bcd_mod_counter;
  localparam int N = 8;
  localparam int MODS [N] = '{60, 24, 12, 2, 100, 60, 60, 24};
  localparam int MINS [N] = '{0, 0, 1, 0, 0, 0, 0, 0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick [N];
  logic dir [N];
  logic clr [N];
  logic ld [N];
  logic [3:0] lo [N];
  logic [3:0] lt [N];
  logic [3:0] ones [N];
  logic [3:0] tens [N];
  logic carry [N];
  logic at_max [N];
  logic err [N];
  int mv [N];
  logic mc [N];
  logic me [N];
  int tests = 0;
  int fails = 0;
  bit chk = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    bcd_mod_counter #(.MODULUS(MODS[g]), .MIN_VALUE(MINS[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .tick_i(tick[g]), .dir_i(dir[g]), .clear_i(clr[g]),
      .load_i(ld[g]), .load_ones_i(lo[g]), .load_tens_i(lt[g]), .ones_o(ones[g]),
      .tens_o(tens[g]), .carry_o(carry[g]), .at_max_o(at_max[g]), .load_err_o(err[g])
    );
  end

  task automatic check(string nm, int i, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, i, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = MINS[i];
      mc[i] = 1'b0;
      me[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int mx = MINS[i] + MODS[i] - 1;
      int lv = int'(lt[i]) * 10 + int'(lo[i]);
      mc[i] = 1'b0;
      me[i] = 1'b0;
      if (clr[i]) mv[i] = MINS[i];
      else if (ld[i]) begin
        if (lo[i] <= 9 && lt[i] <= 9 && lv >= MINS[i] && lv <= mx) mv[i] = lv;
        else me[i] = 1'b1;
      end else if (tick[i]) begin
        if (!dir[i]) begin
          if (mv[i] == mx) begin mv[i] = MINS[i]; mc[i] = 1'b1; end
          else mv[i]++;
        end else begin
          if (mv[i] == MINS[i]) begin mv[i] = mx; mc[i] = 1'b1; end
          else mv[i]--;
        end
      end
    end
  endtask

  always @(negedge clk)
    if (chk)
      for (int i = 0; i < N; i++) begin
        check("ones", i, 8'(ones[i]), 8'(mv[i] % 10));
        check("tens", i, 8'(tens[i]), 8'(mv[i] / 10));
        check("carry", i, 8'(carry[i]), 8'(mc[i]));
        check("load_err", i, 8'(err[i]), 8'(me[i]));
        check("at_max", i, 8'(at_max[i]), 8'(mv[i] == MINS[i] + MODS[i] - 1));
      end

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      tick[i] = 1'b0; dir[i] = 1'b0; clr[i] = 1'b0; ld[i] = 1'b0; lo[i] = 4'd0; lt[i] = 4'd0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic lit(string nm, int i, int v, logic c, logic e);
    check({nm, "_ones"}, i, 8'(ones[i]), 8'(v % 10));
    check({nm, "_tens"}, i, 8'(tens[i]), 8'(v / 10));
    check({nm, "_carry"}, i, 8'(carry[i]), 8'(c));
    check({nm, "_err"}, i, 8'(err[i]), 8'(e));
  endtask

  initial begin
    idle();
    model_reset();
    #17 rst_n = 1'b1;
    @(negedge clk);
    chk = 1'b1;
    lit("rst", 0, 0, 1'b0, 1'b0);
    lit("rst", 2, 1, 1'b0, 1'b0);
    check("rst_at_max", 0, 8'(at_max[0]), 8'd0);
    // mod 60 full revolution
    tick[0] = 1'b1;
    for (int k = 0; k < 59; k++) cyc();
    lit("t1_59", 0, 59, 1'b0, 1'b0);
    check("t1_at_max59", 0, 8'(at_max[0]), 8'd1);
    cyc();
    lit("t1_wrap", 0, 0, 1'b1, 1'b0);
    check("t1_at_max0", 0, 8'(at_max[0]), 8'd0);
    // mod 24: load 23, down, up, up
    idle(); ld[1] = 1'b1; lt[1] = 4'd2; lo[1] = 4'd3; cyc();
    idle(); tick[1] = 1'b1; dir[1] = 1'b1; cyc();
    lit("t2_22", 1, 22, 1'b0, 1'b0);
    dir[1] = 1'b0; cyc();
    lit("t2_23", 1, 23, 1'b0, 1'b0);
    cyc();
    lit("t2_wrap", 1, 0, 1'b1, 1'b0);
    // mod 12, min 1: down-wrap then three rejected loads
    idle(); tick[2] = 1'b1; dir[2] = 1'b1; cyc();
    lit("t3_wrap", 2, 12, 1'b1, 1'b0);
    idle(); ld[2] = 1'b1; cyc();
    lit("t3_ld00", 2, 12, 1'b0, 1'b1);
    idle(); ld[2] = 1'b1; lt[2] = 4'd1; lo[2] = 4'd3; cyc();
    lit("t3_ld13", 2, 12, 1'b0, 1'b1);
    idle(); ld[2] = 1'b1; lo[2] = 4'hA; cyc();
    lit("t3_ld0A", 2, 12, 1'b0, 1'b1);
    idle(); cyc();
    lit("t3_hold", 2, 12, 1'b0, 1'b0);
    // priority at 59
    idle(); ld[0] = 1'b1; lt[0] = 4'd5; lo[0] = 4'd9; cyc();
    clr[0] = 1'b1; lt[0] = 4'd3; lo[0] = 4'd7; tick[0] = 1'b1; cyc();
    lit("t4_clr", 0, 0, 1'b0, 1'b0);
    clr[0] = 1'b0; cyc();
    lit("t4_ld37", 0, 37, 1'b0, 1'b0);
    // mod 2 back-to-back wraps
    idle(); tick[3] = 1'b1; cyc();
    lit("m2_a", 3, 1, 1'b0, 1'b0);
    cyc();
    lit("m2_b", 3, 0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc();
    // cascade seconds -> minutes -> hours from 23:59:58
    idle();
    ld[5] = 1'b1; lt[5] = 4'd5; lo[5] = 4'd8;
    ld[6] = 1'b1; lt[6] = 4'd5; lo[6] = 4'd9;
    ld[7] = 1'b1; lt[7] = 4'd2; lo[7] = 4'd3;
    cyc();
    idle();
    for (int k = 1; k <= 6; k++) begin
      tick[5] = 1'b1; tick[6] = carry[5]; tick[7] = carry[6];
      cyc();
      if (k == 2) lit("cas_s", 5, 0, 1'b1, 1'b0);
      if (k == 3) lit("cas_m", 6, 0, 1'b1, 1'b0);
      if (k == 4) begin lit("cas_h", 7, 0, 1'b1, 1'b0); lit("cas_s4", 5, 2, 1'b0, 1'b0); end
      if (k == 5) lit("cas_h5", 7, 0, 1'b0, 1'b0);
    end
    // asynchronous reset mid-count at 45 with tick high
    idle(); ld[0] = 1'b1; lt[0] = 4'd4; lo[0] = 4'd5; ld[2] = 1'b1; lt[2] = 4'd0; lo[2] = 4'd9; cyc();
    idle(); tick[0] = 1'b1; tick[2] = 1'b1;
    @(posedge clk);
    model_step();
    #2 rst_n = 1'b0;
    #1;
    lit("arst", 0, 0, 1'b0, 1'b0);
    lit("arst", 2, 1, 1'b0, 1'b0);
    check("arst_at_max", 0, 8'(at_max[0]), 8'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc();
    lit("arst_rel", 0, 1, 1'b0, 1'b0);
    // random traffic on all instances
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        int r = int'($urandom_range(0, 15));
        clr[i] = r == 0;
        ld[i] = r == 1 || r == 2;
        tick[i] = $urandom_range(0, 3) != 0;
        dir[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
          int v = MINS[i] + int'($urandom_range(0, MODS[i] - 1));
          lt[i] = 4'(v / 10); lo[i] = 4'(v % 10);
        end else begin
          lt[i] = 4'($urandom); lo[i] = 4'($urandom);
        end
      end
      cyc();
    end
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
